cas_pair_feeder: RTL and testbench
==================================

// Module: cas_pair_feeder
// PURPOSE
//  Source end of the CAS compare-and-swap lane interface (valid/index/value x2).
//  Reads COUNT FP32 elements from a dual-read-port RAM starting at BASE_ADDR.
//  Emits them two per cycle into the first CAS stage, tagging each value with its address.
//  Shares the CAS global enable so the feeder and the network stall together.
// PARAMETERS
//  ADDRW  10  element address / index width
//  WL     32  value width (FP32 bit pattern, passed through untouched)
// PORTS
//  clk        in   1        clock; all state changes on rising edge
//  rst        in   1        synchronous, active-high reset
//  ena        in   1        global enable; 0 = freeze all state and outputs
//  start      in   1        start request, sampled only in IDLE with ena=1
//  base_addr  in   ADDRW    first element address, captured on start
//  count      in   ADDRW+1  element count 0..2^ADDRW, captured on start
//  busy       out  1        1 from the cycle after start acceptance until done
//  done       out  1        1-cycle completion pulse (held while ena=0)
//  rd_en      out  1        RAM read strobe
//  rd_addr1   out  ADDRW    lane-1 read address
//  rd_addr2   out  ADDRW    lane-2 read address
//  rd_data1   in   WL       lane-1 data, valid 1 cycle after rd_en; RAM holds it while rd_en=0
//  rd_data2   in   WL       lane-2 data, same timing as rd_data1
//  valid1     out  1        lane-1 valid to CAS
//  valid2     out  1        lane-2 valid to CAS
//  index1     out  ADDRW    lane-1 index (element address)
//  index2     out  ADDRW    lane-2 index (element address)
//  value1     out  WL       lane-1 value
//  value2     out  WL       lane-2 value
// BEHAVIOUR
//  Reset: state IDLE; busy, done, rd_en, valid*, index*, value* = 0; internal counters = 0.
//  Reset mid-stream aborts immediately; in-flight reads are discarded.
//  ena=0: FSM, counters and output registers hold; rd_en=0.
//  Nothing is lost across a stall because the RAM holds its read data.
//  FSM (advances only when ena=1):
//  - IDLE: on start, capture base_addr/count, set off=0, go to FETCH (count=0 goes to DONE).
//  - FETCH: rd_en=1, rd_addr1=base+off, rd_addr2=base+off+1, both mod 2^ADDRW.
//    The lane valid tags are (off<count) and (off+1<count).
//    Each enabled cycle does off+=2; after the pair where off+2>=count, go to DRAIN.
//  - DRAIN: rd_en=0; wait for the last pair to reach the outputs, then go to DONE.
//  - DONE: done=1 for one enabled cycle, then go to IDLE.
//  Latency: the pair requested in enabled cycle k appears on valid/index/value in enabled cycle k+2.
//  This is a 2-stage pipeline: RAM read, then output register.
//  - Index and valid tags are delayed alongside the data.
//  - One pair per enabled cycle, no bubbles within a stream.
//  Invalid lane (odd count tail, or no pair in flight): valid=0, index=0, value=0.
//  done pulse and busy: done asserts in the enabled cycle after the last valid pair.
//  busy deasserts together with the done pulse.
//  count=0: start -> DONE next cycle; done pulses; no valid ever asserted.
//  start outside IDLE is ignored; base_addr/count changes after capture have no effect.
//  Output registers update only when ena=1, matching CAS input sampling.
// TESTING (RAM preloaded mem[i] = FP32(i), e.g. mem[1]=32'h3F800000)
//  1. base=0 count=4:
//     -> cycle +3: (1,1,idx0,idx1,0.0,1.0); cycle +4: (1,1,2,3,2.0,3.0)
//     -> cycle +5: done=1; busy low after.
//  2. base=5 count=3:
//     -> pairs (5,6) both valid, then (7,-) with valid2=0, index2=0, value2=0; single done pulse.
//  3. count=0:
//     -> done pulses 1 cycle after start acceptance; valid1/valid2 stay 0; rd_en never asserts.
//  4. base=1022 count=4 with ena=0 for 3 cycles after the first pair:
//     -> indices 1022,1023,0,1 in order; outputs and done frozen during the stall; nothing dropped.
//  5. rst=1 mid-FETCH, then a second start while busy:
//     -> reset zeroes all outputs next cycle and returns to IDLE.
//     -> restarting with new base/count streams the new range only; a start pulse while busy is ignored.

Source files
------------

// File: rtl/cas_pair_feeder.sv
// cas_pair_feeder: streams COUNT RAM elements starting at BASE two per cycle into the CAS lane pair
module cas_pair_feeder #(
   parameter int ADDRW = 10,
   parameter int WL    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             start,
   input  logic [ADDRW-1:0] base_addr,
   input  logic [ADDRW:0]   count,
   output logic             busy,
   output logic             done,
   output logic             rd_en,
   output logic [ADDRW-1:0] rd_addr1,
   output logic [ADDRW-1:0] rd_addr2,
   input  logic [WL-1:0]    rd_data1,
   input  logic [WL-1:0]    rd_data2,
   output logic             valid1,
   output logic             valid2,
   output logic [ADDRW-1:0] index1,
   output logic [ADDRW-1:0] index2,
   output logic [WL-1:0]    value1,
   output logic [WL-1:0]    value2
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;
   localparam logic [ADDRW+1:0] OFF_ONE = 1;
   localparam logic [ADDRW+1:0] OFF_TWO = 2;

   logic [1:0]       r_state;
   logic [ADDRW-1:0] r_base;
   logic [ADDRW:0]   r_cnt;
   logic [ADDRW+1:0] r_off;
   logic             r_s1_live, r_s1_v1, r_s1_v2;
   logic [ADDRW-1:0] r_s1_i1, r_s1_i2;
   logic             r_valid1, r_valid2;
   logic [ADDRW-1:0] r_index1, r_index2;
   logic [WL-1:0]    r_value1, r_value2;
   logic             w_fetch, w_v1, w_v2;
   logic [ADDRW+1:0] w_off1, w_off2, w_cnt;

   assign w_fetch  = r_state == S_FETCH;
   assign w_off1   = r_off + OFF_ONE;
   assign w_off2   = r_off + OFF_TWO;
   assign w_cnt    = {1'b0, r_cnt};
   assign w_v1     = w_fetch && (r_off < w_cnt);
   assign w_v2     = w_fetch && (w_off1 < w_cnt);
   assign rd_en    = w_fetch && ena;
   assign rd_addr1 = r_base + r_off[ADDRW-1:0];
   assign rd_addr2 = r_base + w_off1[ADDRW-1:0];
   assign busy     = (r_state == S_FETCH) || (r_state == S_DRAIN);
   assign done     = r_state == S_DONE;
   assign valid1   = r_valid1;
   assign valid2   = r_valid2;
   assign index1   = r_index1;
   assign index2   = r_index2;
   assign value1   = r_value1;
   assign value2   = r_value2;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_base    <= '0;
         r_cnt     <= '0;
         r_off     <= '0;
         r_s1_live <= 1'b0;
         r_s1_v1   <= 1'b0;
         r_s1_v2   <= 1'b0;
         r_s1_i1   <= '0;
         r_s1_i2   <= '0;
         r_valid1  <= 1'b0;
         r_valid2  <= 1'b0;
         r_index1  <= '0;
         r_index2  <= '0;
         r_value1  <= '0;
         r_value2  <= '0;
      end else if (ena) begin
         case (r_state)
            S_IDLE: if (start) begin
               r_base  <= base_addr;
               r_cnt   <= count;
               r_off   <= '0;
               r_state <= (count == '0) ? S_DONE : S_FETCH;
            end
            S_FETCH: begin
               r_off <= w_off2;
               if (w_off2 >= w_cnt) r_state <= S_DRAIN;
            end
            S_DRAIN: if (!r_s1_live) r_state <= S_DONE;
            default: r_state <= S_IDLE;
         endcase
         // tags travel alongside the RAM read so they meet the data at the output register
         r_s1_live <= w_fetch;
         r_s1_v1   <= w_v1;
         r_s1_v2   <= w_v2;
         r_s1_i1   <= w_v1 ? rd_addr1 : '0;
         r_s1_i2   <= w_v2 ? rd_addr2 : '0;
         r_valid1  <= r_s1_v1;
         r_valid2  <= r_s1_v2;
         r_index1  <= r_s1_i1;
         r_index2  <= r_s1_i2;
         r_value1  <= r_s1_v1 ? rd_data1 : '0;
         r_value2  <= r_s1_v2 ? rd_data2 : '0;
      end
   end
endmodule

// File: tb/tb_cas_pair_feeder.sv
// tb_cas_pair_feeder: randomized stream checks against a timeline model of the feeder
module tb_cas_pair_feeder;
   localparam int ADDRW = 10;
   localparam int WL    = 32;

   logic             clk = 1'b0;
   logic             rst = 1'b1, ena = 1'b0, start = 1'b0;
   logic [ADDRW-1:0] base_addr = '0;
   logic [ADDRW:0]   count = '0;
   logic             busy, done, rd_en, valid1, valid2;
   logic [ADDRW-1:0] rd_addr1, rd_addr2, index1, index2;
   logic [WL-1:0]    rd_data1 = '0, rd_data2 = '0, value1, value2;
   logic [WL-1:0]    mem [0:1023];
   int               checks = 0, failures = 0;

   cas_pair_feeder #(.ADDRW(ADDRW), .WL(WL)) dut (
      .clk(clk), .rst(rst), .ena(ena), .start(start), .base_addr(base_addr), .count(count),
      .busy(busy), .done(done), .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(rd_data1), .rd_data2(rd_data2), .valid1(valid1), .valid2(valid2),
      .index1(index1), .index2(index2), .value1(value1), .value2(value2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (rd_en) begin
      rd_data1 <= mem[rd_addr1];
      rd_data2 <= mem[rd_addr2];
   end

   function automatic logic [31:0] fp32(input int v);
      int e;
      if (v == 0) return 32'h0;
      e = 0;
      while ((v >> (e + 1)) != 0) e++;
      return {1'b0, 8'(e + 127), 23'((v << (23 - e)) & 32'h7fffff)};
   endfunction

   // n = enabled edges since start acceptance; every output is a function of n alone
   task automatic test_stream(input string name, input int b, input int c, input int mode);
      int n, p, np, last, stall, guard, ei1, ei2;
      logic ev1, ev2, edone, ebusy, erd;
      logic [31:0] ex1, ex2;
      logic [88:0] obs, exp_v;
      np = (c + 1) / 2;
      last = (c == 0) ? 1 : np + 3;
      @(posedge clk); #1;
      rst = 0; ena = 1; start = 1; base_addr = ADDRW'(b); count = (ADDRW+1)'(c); #1;
      checks++;
      if ({busy, done} !== 2'b00) begin
         failures++;
         $display("FAIL %s accept busy/done=%b expected 00", name, {busy, done});
      end
      n = 1; stall = 0; guard = 0;
      while (n <= last + 1 && guard < 3000) begin
         @(posedge clk); #1;
         ena = (mode == 0) ? 1'b1 : (mode == 1) ? ($urandom_range(0, 9) < 7) : !(n == 3 && stall < 3);
         if (mode == 2 && !ena) stall++;
         if (n > last) ena = 1;
         start = (n <= last) ? 1'($urandom_range(0, 1)) : 1'b0;
         base_addr = ADDRW'($urandom);
         count = (ADDRW+1)'($urandom);
         #1;
         p = n - 3; ev1 = 0; ev2 = 0; ei1 = 0; ei2 = 0; ex1 = 0; ex2 = 0;
         if (c > 0 && p >= 0 && p < np) begin
            ev1 = 1; ei1 = (b + 2 * p) % 1024; ex1 = fp32(ei1);
            if (2 * p + 1 < c) begin ev2 = 1; ei2 = (b + 2 * p + 1) % 1024; ex2 = fp32(ei2); end
         end
         edone = (n == last);
         ebusy = c > 0 && n < np + 3;
         erd = ena && c > 0 && n <= np;
         exp_v = {ebusy, edone, erd, ev1, ev2, ADDRW'(ei1), ADDRW'(ei2), ex1, ex2};
         obs = {busy, done, rd_en, valid1, valid2, index1, index2, value1, value2};
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s n=%0d got=%h expected=%h", name, n, obs, exp_v);
         end
         if (erd) begin
            checks++;
            if ({rd_addr1, rd_addr2} !== {ADDRW'(b + 2 * (n - 1)), ADDRW'(b + 2 * (n - 1) + 1)}) begin
               failures++;
               $display("FAIL %s rd_addr n=%0d got=%0d,%0d", name, n, rd_addr1, rd_addr2);
            end
         end
         if (ena) n++;
         guard++;
      end
      start = 0;
      checks++;
      if (guard >= 3000) begin
         failures++;
         $display("FAIL %s timeout n=%0d expected %0d", name, n, last + 2);
      end
   endtask

   task automatic test_reset();
      rst = 1; ena = 0; start = 1;
      repeat (2) @(posedge clk);
      #2;
      checks++;
      if ({busy, done, rd_en, valid1, valid2, index1, index2, value1, value2} !== '0) begin
         failures++;
         $display("FAIL reset outputs busy=%b done=%b valid=%b%b expected all 0", busy, done, valid1, valid2);
      end
   endtask

   task automatic test_ena_gate();
      @(posedge clk); #1; rst = 0; ena = 0; start = 1;
      repeat (2) @(posedge clk);
      #1; start = 0; #1;
      checks++;
      if ({busy, done} !== 2'b00) begin
         failures++;
         $display("FAIL ena_gate busy/done=%b expected 00", {busy, done});
      end
   endtask

   task automatic test_mid_reset();
      @(posedge clk); #1; ena = 1; start = 1; base_addr = 100; count = 20;
      repeat (4) begin @(posedge clk); #1; start = 0; end
      #1;
      checks++;
      if ({valid1, index1, value1} !== {1'b1, 10'd102, fp32(102)}) begin
         failures++;
         $display("FAIL mid_stream got v=%b idx=%0d val=%h expected 1,102", valid1, index1, value1);
      end
      @(posedge clk); #1; rst = 1;
      @(posedge clk); #1; rst = 0; #1;
      checks++;
      if ({busy, done, valid1, valid2, index1, index2, value1, value2} !== '0) begin
         failures++;
         $display("FAIL mid_reset busy=%b v=%b%b idx=%0d expected zeros", busy, valid1, valid2, index1);
      end
      test_stream("restart", 300, 7, 1);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = fp32(i);
      test_reset();
      test_ena_gate();
      test_stream("basic", 0, 4, 0);
      test_stream("odd_tail", 5, 3, 0);
      test_stream("count0", 0, 0, 0);
      test_stream("single", 9, 1, 0);
      test_stream("wrap_stall", 1022, 4, 2);
      test_mid_reset();
      for (int k = 0; k < 6; k++)
         test_stream("random", int'($urandom_range(0, 1023)), int'($urandom_range(0, 40)), 1);
      test_stream("full", 1023, 1024, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
